// File: rtl/memoria_param.sv
// memoria_param -- single-port word memory with per-byte write enables,
// a one-cycle registered response and an optional zero-fill sweep after reset.
//
// Build option: define MEMORIA_CLEAR_EN to compile the clear sweep.  Without it
// the block is ready straight out of reset and contents start uninitialised.
//
// Ports
//   clk        in   single clock, everything updates on its rising edge
//   reset      in   synchronous, active-low
//   req_valid  in   request present
//   req_ready  out  request can be accepted this cycle
//   req_write  in   1 = write, 0 = read
//   req_addr   in   [ADDR_W-1:0] word address
//   req_data   in   [DATA_W-1:0] write data
//   req_be     in   [DATA_W/8-1:0] byte enables, bit i covers bits 8i+7..8i
//   rsp_valid  out  one-cycle response pulse, one cycle after acceptance
//   rsp_data   out  [DATA_W-1:0] read data, holds its value across writes
//   rsp_err    out  address out of range, qualified by rsp_valid
//   busy       out  clear sweep in progress
module memoria_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_data,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_err,
  output logic                busy
);

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic             accept;
  logic             in_range;
  logic [IDX_W-1:0] req_idx;
  logic             ready_r;
  logic             busy_r;

  // The full address is range-checked before the truncated index is used,
  // so out-of-range addresses never alias onto a real word.
  assign accept    = req_valid & ready_r & reset;
  assign in_range  = ({1'b0, req_addr} < DEPTH_L);
  assign req_idx   = req_addr[IDX_W-1:0];
  assign req_ready = ready_r;

`ifdef MEMORIA_CLEAR_EN
  typedef enum logic {CLEAR, READY} state_t;

  localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);

  state_t          state;
  logic [ADDR_W:0] sweep_cnt;

  // Sweep counter is one bit wider than the address so it cannot wrap
  // before reaching DEPTH-1, even when DEPTH == 2**ADDR_W.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= CLEAR;
      sweep_cnt <= '0;
      busy_r    <= 1'b1;
      ready_r   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (sweep_cnt == LAST) begin
            state   <= READY;
            busy_r  <= 1'b0;
            ready_r <= 1'b1;
          end else begin
            sweep_cnt <= sweep_cnt + 1'b1;
          end
        end
        READY: begin
          busy_r  <= 1'b0;
          ready_r <= 1'b1;
        end
        default: begin
          state     <= CLEAR;
          sweep_cnt <= '0;
          busy_r    <= 1'b1;
          ready_r   <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_r;
`else
  typedef enum logic {READY} state_t;

  state_t state;

  // Without the sweep the block is ready as soon as reset is applied.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= READY;
      busy_r  <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      case (state)
        READY: begin
          busy_r  <= 1'b0;
          ready_r <= 1'b1;
        end
        default: begin
          state   <= READY;
          busy_r  <= 1'b0;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign busy = 1'b0;
`endif

  // Memory array has no reset; only the sweep or accepted writes change it.
  always_ff @(posedge clk) begin
`ifdef MEMORIA_CLEAR_EN
    if (reset && state == CLEAR) begin
      mem[sweep_cnt[IDX_W-1:0]] <= '0;
    end else
`endif
    if (accept && req_write && in_range) begin
      for (int b = 0; b < BYTES; b++) begin
        if (req_be[b]) begin
          mem[req_idx][8*b +: 8] <= req_data[8*b +: 8];
        end
      end
    end
  end

  // Registered response: a read sees any write accepted on an earlier edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= accept;
      if (accept) begin
        rsp_err <= ~in_range;
        if (!req_write) begin
          rsp_data <= in_range ? mem[req_idx] : '0;
        end
      end
    end
  end

endmodule

// File: doc/memoria_param.md
MEMORIA_PARAM -- requirements
Module: memoria_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning word width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 10, meaning request address width.
REQ-003 SHALL have parameter DEPTH, default 1024, meaning number of stored words; DEPTH <= 2**ADDR_W.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on posedge clk.
REQ-005 SHALL have port reset  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  request can be accepted this cycle.
REQ-008 SHALL have port req_write  input  1  1 = write, 0 = read.
REQ-009 SHALL have port req_addr  input  ADDR_W  word address.
REQ-010 SHALL have port req_data  input  DATA_W  write data.
REQ-011 SHALL have port req_be  input  DATA_W/8  per-byte write enable; bit i covers bits 8i+7..8i.
REQ-012 SHALL have port rsp_valid  output  1  one-cycle response pulse.
REQ-013 SHALL have port rsp_data  output  DATA_W  read data.
REQ-014 SHALL have port rsp_err  output  1  address-range error, qualified by rsp_valid.
REQ-015 SHALL have port busy  output  1  clear sweep in progress.

Function
REQ-016 SHALL accept a request on a posedge where req_valid=1 and req_ready=1; no other cycle has effect.
REQ-017 SHALL assert rsp_valid for exactly one cycle, in the cycle after every accepted request (latency 1, read or write).
REQ-018 SHALL drive rsp_data with mem[req_addr] for an accepted in-range read; rsp_data holds its previous value after writes.
REQ-019 SHALL update only bytes whose req_be bit is 1 on an accepted in-range write; req_be=0 is a legal no-op write with a response.
REQ-020 SHALL treat req_addr >= DEPTH as out-of-range: write discarded, read returns rsp_data=0, rsp_err=1 with the response; rsp_err=0 otherwise.
REQ-021 SHALL return newly written data for a read accepted the cycle after a write to the same address (back-to-back, no stall).
REQ-022 SHALL implement FSM states CLEAR and READY; req_ready=1 only in READY; busy=1 only in CLEAR.
REQ-023 SHALL in CLEAR write 0 to one word per cycle, addresses 0..DEPTH-1 ascending, then enter READY on the cycle after writing DEPTH-1 (DEPTH cycles busy).
REQ-024 SHALL keep req_ready=1 continuously in READY; the block never back-pressures after the sweep.
REQ-025 SHALL never alias: the sweep counter is ADDR_W+1 bits wide and does not wrap before DEPTH is reached.

Reset
REQ-026 SHALL on reset=0 at a posedge: rsp_valid=0, rsp_err=0, rsp_data=0, sweep counter=0, FSM to CLEAR (or READY per REQ-029).
REQ-027 SHALL drop any response pending from the request accepted in the cycle reset is sampled; no rsp_valid follows reset.
REQ-028 SHALL restart the sweep at address 0 if reset is asserted mid-sweep; memory contents are not otherwise touched by reset.

Configuration
REQ-029 SHALL compile the clear sweep only when macro MEMORIA_CLEAR_EN is defined; without it there is no CLEAR state, the FSM enters READY on reset, busy is tied 0, req_ready=1 from the first cycle after reset release, and contents are uninitialised until written.

Verification
REQ-030 SHALL cover: with MEMORIA_CLEAR_EN, DEPTH=16, release reset -> busy=1 and req_ready=0 for exactly 16 cycles, then reads of addr 0..15 return 0 with rsp_err=0.
REQ-031 SHALL cover: write addr 5 data 0x12345678 be=1111, then write addr 5 data 0xAABBCCDD be=0101, read addr 5 -> rsp_data=0x12BB56DD one cycle after acceptance.
REQ-032 SHALL cover: write addr 7 = 0xCAFEF00D followed immediately by read addr 7 -> rsp_data=0xCAFEF00D, rsp_valid on two consecutive cycles.
REQ-033 SHALL cover: DEPTH=16, ADDR_W=5, read addr 20 -> rsp_valid=1, rsp_err=1, rsp_data=0; write addr 20 then read addr 4 -> addr 4 unchanged.
REQ-034 SHALL cover: reset asserted at sweep address 9, released -> sweep restarts at 0 and busy lasts a full DEPTH cycles again; reset in the cycle of an accepted read -> no rsp_valid.
REQ-035 SHALL cover: without MEMORIA_CLEAR_EN, release reset -> busy=0, req_ready=1 in the first cycle, write then read addr 3 = 0x00000001 returns 0x00000001.
